// File: rtl/counter_pkg.sv
// Shared definitions for the cascaded modulo counter: FSM encoding and an
// elaboration-time clog2 helper.
package counter_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((r < 32) && ((64'd1 << r) < 64'(v))) r++;
    return r;
  endfunction

endpackage

// File: rtl/counter_digit.sv
// One modulo-P_BASE up/down digit with synchronous clear, clamped load and
// carry-out when stepping across its terminal value.
module counter_digit #(
  parameter int unsigned P_BASE = 10,
  parameter int unsigned P_BIT  = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             load,
  input  logic [P_BIT-1:0] load_d,
  input  logic             cin,
  input  logic             up_dw,
  output logic [P_BIT-1:0] q,
  output logic             cout
);

  localparam logic [P_BIT-1:0] MaxVal = P_BIT'(P_BASE - 1);

  logic [P_BIT-1:0] q_d, q_q;
  logic             at_term;

  assign at_term = up_dw ? (q_q == MaxVal) : (q_q == '0);
  assign cout    = cin & at_term;
  assign q       = q_q;

  // Clear beats load beats count; loads above the modulo clamp to MaxVal.
  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (load) begin
      q_d = (load_d > MaxVal) ? MaxVal : load_d;
    end else if (cin) begin
      if (at_term) q_d = up_dw ? '0 : MaxVal;
      else         q_d = up_dw ? (q_q + 1'b1) : (q_q - 1'b1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) q_q <= '0;
    else         q_q <= q_d;
  end

endmodule

// File: rtl/cascade_counter.sv
// Multi-digit cascaded modulo up/down counter with clear, clamped parallel
// load, per-digit carries and a one-shot mode that halts after a full wrap.
module cascade_counter
  import counter_pkg::*;
#(
  parameter int unsigned P_BASE   = 10,
  parameter int unsigned P_BIT    = 4,
  parameter int unsigned P_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      enable,
  input  logic                      up_dw,
  input  logic                      clear,
  input  logic                      load,
  input  logic [P_DIGITS*P_BIT-1:0] load_value,
  input  logic                      oneshot,
  output logic [P_DIGITS*P_BIT-1:0] count,
  output logic [P_DIGITS-1:0]       digit_carry,
  output logic                      carry,
  output logic                      done
);

  if ((P_BASE < 2) || (P_BIT < clog2(P_BASE)) || (P_DIGITS < 1)) begin : g_param_check
    $error("cascade_counter: illegal parameters P_BASE=%0d P_BIT=%0d P_DIGITS=%0d",
           P_BASE, P_BIT, P_DIGITS);
  end

  state_e                state_d, state_q;
  logic                  done_d, done_q;
  logic [P_DIGITS-1:0]   cin;

  assign cin[0] = enable & (state_q == ST_RUN);
  assign carry  = digit_carry[P_DIGITS-1];
  assign done   = done_q;

  for (genvar i = 0; i < P_DIGITS; i++) begin : g_digit
    counter_digit #(
      .P_BASE (P_BASE),
      .P_BIT  (P_BIT)
    ) u_digit (
      .clk    (clk),
      .resetn (resetn),
      .clear  (clear),
      .load   (load),
      .load_d (load_value[i*P_BIT +: P_BIT]),
      .cin    (cin[i]),
      .up_dw  (up_dw),
      .q      (count[i*P_BIT +: P_BIT]),
      .cout   (digit_carry[i])
    );
    if (i < P_DIGITS - 1) begin : g_chain
      assign cin[i+1] = digit_carry[i];
    end
  end

  // Halt only on a genuine full wrap; clear/load always win and resume RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (!clear && !load && carry && oneshot) state_d = ST_HALT;
      ST_HALT: if (clear || load) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
    done_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_RUN;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_cascade_counter.sv
// Directed self-checking bench for cascade_counter (base 10, 4 digits).
module tb_cascade_counter;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic        up_dw;
  logic        clear;
  logic        load;
  logic [15:0] load_value;
  logic        oneshot;
  logic [15:0] count;
  logic [3:0]  digit_carry;
  logic        carry;
  logic        done;

  int errors;
  int checks;

  cascade_counter #(
    .P_BASE   (10),
    .P_BIT    (4),
    .P_DIGITS (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .up_dw       (up_dw),
    .clear       (clear),
    .load        (load),
    .load_value  (load_value),
    .oneshot     (oneshot),
    .count       (count),
    .digit_carry (digit_carry),
    .carry       (carry),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load       = 1'b1;
    load_value = v;
    step();
    load       = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b0; up_dw = 1'b1; clear = 1'b0;
    load = 1'b0; load_value = '0; oneshot = 1'b0;
    #12;
    checks++;
    if (count !== 16'h0000 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%h done=%b, required 0000/0", count, done);
    end
    checks++;
    if (carry !== 1'b0 || digit_carry !== 4'b0000) begin
      errors++;
      $display("FAIL reset_carry: carry=%b dc=%b, required 0/0000", carry, digit_carry);
    end
    #2 resetn = 1'b1;
    step();
  endtask

  task automatic test_up_cascade();
    do_load(16'h0999);
    up_dw = 1'b1; enable = 1'b1;
    #1;
    checks++;
    if (digit_carry !== 4'b0111 || carry !== 1'b0) begin
      errors++;
      $display("FAIL up_dc: dc=%b carry=%b, required 0111/0", digit_carry, carry);
    end
    step();
    enable = 1'b0;
    checks++;
    if (count !== 16'h1000) begin
      errors++;
      $display("FAIL up_cascade: count=%h, required 1000", count);
    end
  endtask

  task automatic test_down_wrap();
    clear = 1'b1; step(); clear = 1'b0;
    up_dw = 1'b0; enable = 1'b1;
    #1;
    checks++;
    if (carry !== 1'b1 || digit_carry !== 4'b1111) begin
      errors++;
      $display("FAIL down_carry: carry=%b dc=%b, required 1/1111", carry, digit_carry);
    end
    step();
    enable = 1'b0;
    checks++;
    if (count !== 16'h9999 || done !== 1'b0) begin
      errors++;
      $display("FAIL down_wrap: count=%h done=%b, required 9999/0", count, done);
    end
  endtask

  task automatic test_oneshot();
    do_load(16'h9998);
    up_dw = 1'b1; oneshot = 1'b1; enable = 1'b1;
    step();
    checks++;
    if (count !== 16'h9999 || carry !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL os_pre: count=%h carry=%b done=%b, required 9999/1/0", count, carry, done);
    end
    step();
    checks++;
    if (count !== 16'h0000 || done !== 1'b1 || carry !== 1'b0) begin
      errors++;
      $display("FAIL os_wrap: count=%h done=%b carry=%b, required 0000/1/0", count, done, carry);
    end
    oneshot = 1'b0;
    step();
    checks++;
    if (count !== 16'h0000 || done !== 1'b1 || digit_carry !== 4'b0000) begin
      errors++;
      $display("FAIL os_halt: count=%h done=%b dc=%b, required 0000/1/0000", count, done, digit_carry);
    end
    do_load(16'h0005);
    checks++;
    if (count !== 16'h0005 || done !== 1'b0) begin
      errors++;
      $display("FAIL os_reload: count=%h done=%b, required 0005/0", count, done);
    end
    step();
    enable = 1'b0;
    checks++;
    if (count !== 16'h0006) begin
      errors++;
      $display("FAIL os_resume: count=%h, required 0006", count);
    end
  endtask

  task automatic test_priority_clamp();
    clear = 1'b1;
    do_load(16'h1234);
    clear = 1'b0;
    checks++;
    if (count !== 16'h0000) begin
      errors++;
      $display("FAIL prio: count=%h, required 0000", count);
    end
    do_load(16'hFA3C);
    checks++;
    if (count !== 16'h9939) begin
      errors++;
      $display("FAIL clamp: count=%h, required 9939", count);
    end
  endtask

  task automatic test_wrap_vs_load();
    do_load(16'h9999);
    up_dw = 1'b1; oneshot = 1'b1; enable = 1'b1;
    do_load(16'h0042);
    checks++;
    if (count !== 16'h0042 || done !== 1'b0) begin
      errors++;
      $display("FAIL wrap_load: count=%h done=%b, required 0042/0", count, done);
    end
    step();
    checks++;
    if (count !== 16'h0043) begin
      errors++;
      $display("FAIL wrap_load_run: count=%h, required 0043", count);
    end
    oneshot = 1'b0;
    do_load(16'h9999);
    step();
    checks++;
    if (count !== 16'h0000 || done !== 1'b0) begin
      errors++;
      $display("FAIL freerun_wrap: count=%h done=%b, required 0000/0", count, done);
    end
    step();
    enable = 1'b0;
    checks++;
    if (count !== 16'h0001) begin
      errors++;
      $display("FAIL freerun_next: count=%h, required 0001", count);
    end
  endtask

  task automatic test_async_reset();
    do_load(16'h0000);
    up_dw = 1'b0; oneshot = 1'b1; enable = 1'b1;
    step();
    checks++;
    if (count !== 16'h9999 || done !== 1'b1) begin
      errors++;
      $display("FAIL ar_halt: count=%h done=%b, required 9999/1", count, done);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (count !== 16'h0000 || done !== 1'b0) begin
      errors++;
      $display("FAIL ar_immediate: count=%h done=%b, required 0000/0", count, done);
    end
    #1 resetn = 1'b1;
    up_dw = 1'b1; oneshot = 1'b0;
    step();
    enable = 1'b0;
    checks++;
    if (count !== 16'h0001 || done !== 1'b0) begin
      errors++;
      $display("FAIL ar_run: count=%h done=%b, required 0001/0", count, done);
    end
  endtask

  task automatic test_enable_gating();
    do_load(16'h0999);
    up_dw = 1'b1; enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (count !== 16'h0999 || carry !== 1'b0 || digit_carry !== 4'b0000) begin
        errors++;
        $display("FAIL en_gate[%0d]: count=%h carry=%b dc=%b, required 0999/0/0000",
                 k, count, carry, digit_carry);
      end
      step();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_up_cascade();
    test_down_wrap();
    test_oneshot();
    test_priority_clamp();
    test_wrap_vs_load();
    test_async_reset();
    test_enable_gating();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
